// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: oversamples sck/ssel in the clk domain and shifts
// words MSB-first onto miso, fed through a one-word holding register.
module spi_slave_tx #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  ssel,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  ssel_sync;
    logic                    sck_prev;
    logic                    ssel_prev;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    ssel_rise;
    logic                    ssel_fall;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic                    hold_full;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    reload;
    logic                    do_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ssel_sync <= '1;
            sck_prev  <= 1'b0;
            ssel_prev <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], ssel};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            ssel_prev <= ssel_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise  =  sck_sync[SYNC_STAGES-1]  & ~sck_prev;
    assign sck_fall  = ~sck_sync[SYNC_STAGES-1]  &  sck_prev;
    assign ssel_rise =  ssel_sync[SYNC_STAGES-1] & ~ssel_prev;
    assign ssel_fall = ~ssel_sync[SYNC_STAGES-1] &  ssel_prev;

    assign tx_ready = ~hold_full;
    // A deselect seen in the LOAD cycle abandons the load, leaving the holding word intact.
    assign do_load  = (state == LOAD) && !ssel_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
        end else if (do_load && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            reload     <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    if (ssel_fall) begin
                        state   <= LOAD;
                        miso_oe <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ssel_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else begin
                        state     <= SHIFT;
                        shift_reg <= hold_full ? hold_reg : '0;
                        miso      <= hold_full & hold_reg[DATA_WIDTH-1];
                        underrun  <= ~hold_full;
                    end
                end
                SHIFT: begin
                    if (ssel_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                    end else if (sck_rise) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                            reload     <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sck_fall) begin
                        if (reload) begin
                            reload <= 1'b0;
                            state  <= LOAD;
                        end else begin
                            shift_reg <= shift_reg << 1;
                            miso      <= shift_reg[DATA_WIDTH-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
